// File: rtl/dac_wave_seq.sv
// dac_wave_seq: autonomous sawtooth / triangle sample sequencer that feeds the
// DAC SPI serializer through the data/address/command + dactrig/dacdone
// handshake. It raises a sticky overrun flag when samples are requested faster
// than the serializer can take them.
// The triangle path (dir register, mode input) is built only when the macro
// DAC_WAVE_SEQ_TRIANGLE_EN is defined. Otherwise the block is sawtooth only.

module dac_wave_seq #(
    parameter int         PERIOD_W         = 16,
    parameter logic [3:0] CMD_WRITE_UPDATE = 4'b0011
) (
    input  logic                CLK50MHZ,
    input  logic                RST,
    input  logic                en,
    input  logic                mode,
    input  logic [3:0]          chan,
    input  logic [11:0]         step,
    input  logic [PERIOD_W-1:0] period,
    output logic [11:0]         data,
    output logic [3:0]          address,
    output logic [3:0]          command,
    output logic                dactrig,
    input  logic                dacdone,
    output logic                busy,
    output logic                overrun,
    input  logic                clr_ovr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_TRIG = 2'b01,
        ST_WAIT = 2'b10
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic                  en_d_r;
    logic [PERIOD_W-1:0]   cnt_r;
    logic                  en_rise_s;
    logic                  tick_s;
    logic                  pend_r;
    logic                  pend_s;
    logic                  ovr_r;
    logic                  ovr_s;
    logic [11:0]           data_r;
    logic [11:0]           adv_data_s;
    logic [12:0]           sum_s;
    logic [3:0]            addr_r;
    logic [3:0]            cmd_r;
    logic                  dactrig_r;
    logic                  busy_r;
    logic                  enter_trig_s;
    logic                  adv_s;

`ifdef DAC_WAVE_SEQ_TRIANGLE_EN
    logic                  dir_r;
    logic                  adv_dir_s;
    logic                  mode_r;
    logic                  eff_dir_s;
`else
    // mode has no function in the sawtooth-only build.
    logic                  mode_unused_s;
    assign mode_unused_s = mode;
`endif

    // Tick detection: a tick needs a settled enable and an expired counter.
    always_comb begin
        en_rise_s = en & ~en_d_r;
        tick_s    = en & ~en_rise_s & (cnt_r == {PERIOD_W{1'b0}});
    end

    // Sample-interval down-counter: reload on tick or enable rise, hold when disabled.
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            en_d_r <= 1'b0;
            cnt_r  <= {PERIOD_W{1'b0}};
        end else begin
            en_d_r <= en;
            if (en_rise_s || tick_s) begin
                cnt_r <= period;
            end else if (en) begin
                cnt_r <= cnt_r - {{(PERIOD_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Next-state logic for the IDLE -> TRIG -> WAIT handshake sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (tick_s || pend_r) begin
                    state_s = ST_TRIG;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_TRIG: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (dacdone) begin
                    if (pend_r && en) begin
                        state_s = ST_TRIG;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        enter_trig_s = (state_s == ST_TRIG) && (state_r != ST_TRIG);
        adv_s        = (state_r == ST_WAIT) && dacdone;
    end

    // Pending-tick bit and sticky overrun flag.
    always_comb begin
        pend_s = pend_r;
        ovr_s  = ovr_r;
        if (enter_trig_s) begin
            pend_s = 1'b0;
        end else if (adv_s && !en) begin
            pend_s = 1'b0;
        end else if (tick_s) begin
            pend_s = 1'b1;
        end else begin
            pend_s = pend_r;
        end
        if (clr_ovr) begin
            ovr_s = 1'b0;
        end else if (tick_s && pend_r) begin
            ovr_s = 1'b1;
        end else begin
            ovr_s = ovr_r;
        end
    end

    // Next sample value: wrapping add for sawtooth, saturating bounce for triangle.
    always_comb begin
        sum_s      = {1'b0, data_r} + {1'b0, step};
        adv_data_s = sum_s[11:0];
`ifdef DAC_WAVE_SEQ_TRIANGLE_EN
        adv_dir_s  = dir_r;
        // Entering triangle mode always starts on an upward ramp.
        eff_dir_s  = (mode && !mode_r) ? 1'b1 : dir_r;
        if (mode) begin
            if (eff_dir_s) begin
                if (sum_s > 13'd4095) begin
                    adv_data_s = 12'd4095;
                    adv_dir_s  = 1'b0;
                end else begin
                    adv_data_s = sum_s[11:0];
                    adv_dir_s  = 1'b1;
                end
            end else begin
                if (step > data_r) begin
                    adv_data_s = 12'd0;
                    adv_dir_s  = 1'b1;
                end else begin
                    adv_data_s = data_r - step;
                    adv_dir_s  = 1'b0;
                end
            end
        end else begin
            adv_data_s = sum_s[11:0];
            adv_dir_s  = dir_r;
        end
`endif
    end

    // State, handshake outputs and sample registers.
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            pend_r    <= 1'b0;
            ovr_r     <= 1'b0;
            data_r    <= 12'd0;
            addr_r    <= 4'd0;
            cmd_r     <= CMD_WRITE_UPDATE;
            dactrig_r <= 1'b0;
            busy_r    <= 1'b0;
`ifdef DAC_WAVE_SEQ_TRIANGLE_EN
            dir_r     <= 1'b1;
            mode_r    <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            pend_r    <= pend_s;
            ovr_r     <= ovr_s;
            cmd_r     <= CMD_WRITE_UPDATE;
            dactrig_r <= (state_s == ST_TRIG);
            busy_r    <= (state_s != ST_IDLE);
            if (enter_trig_s) begin
                addr_r <= chan;
            end else begin
                addr_r <= addr_r;
            end
            if (adv_s) begin
                data_r <= adv_data_s;
`ifdef DAC_WAVE_SEQ_TRIANGLE_EN
                dir_r  <= adv_dir_s;
                mode_r <= mode;
`endif
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign data    = data_r;
    assign address = addr_r;
    assign command = cmd_r;
    assign dactrig = dactrig_r;
    assign busy    = busy_r;
    assign overrun = ovr_r;

endmodule

// File: tb/tb_dac_wave_seq.sv
// Self-checking bench for dac_wave_seq. Expected samples are produced by a
// small reference model when the bench (acting as the serializer) issues
// dacdone, queued, and compared when the DUT raises dactrig.

module tb_dac_wave_seq;

    localparam int PW = 16;
`ifdef DAC_WAVE_SEQ_TRIANGLE_EN
    localparam bit TRI_ON = 1'b1;
`else
    localparam bit TRI_ON = 1'b0;
`endif

    logic          CLK50MHZ = 1'b0;
    logic          RST      = 1'b1;
    logic          en       = 1'b0;
    logic          mode     = 1'b0;
    logic [3:0]    chan     = 4'd0;
    logic [11:0]   step     = 12'd0;
    logic [PW-1:0] period   = '0;
    logic          dacdone  = 1'b0;
    logic          clr_ovr  = 1'b0;
    logic [11:0]   data;
    logic [3:0]    address;
    logic [3:0]    command;
    logic          dactrig;
    logic          busy;
    logic          overrun;

    dac_wave_seq #(.PERIOD_W(PW), .CMD_WRITE_UPDATE(4'b0011)) dut (
        .CLK50MHZ(CLK50MHZ), .RST(RST), .en(en), .mode(mode), .chan(chan),
        .step(step), .period(period), .data(data), .address(address),
        .command(command), .dactrig(dactrig), .dacdone(dacdone), .busy(busy),
        .overrun(overrun), .clr_ovr(clr_ovr)
    );

    always #5 CLK50MHZ = ~CLK50MHZ;

    int cyc = 0;
    always @(posedge CLK50MHZ) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] exp_q[$];
    int          m_data;
    bit          m_dir;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK50MHZ);
        #1;
    endtask

    // Reference sample advance, pushed to the scoreboard.
    task automatic model_adv();
        int v;
        int s;
        s = int'(step);
        if (TRI_ON && mode) begin
            if (m_dir) begin
                v = m_data + s;
                if (v > 4095) begin
                    v = 4095;
                    m_dir = 1'b0;
                end
            end else begin
                v = m_data - s;
                if (v < 0) begin
                    v = 0;
                    m_dir = 1'b1;
                end
            end
        end else begin
            v = (m_data + s) % 4096;
        end
        m_data = v;
        exp_q.push_back(12'(v));
    endtask

    task automatic do_reset();
        RST = 1'b1; en = 1'b0; dacdone = 1'b0; clr_ovr = 1'b0; mode = 1'b0;
        repeat (2) tick();
        RST = 1'b0;
        tick();
        m_data = 0;
        m_dir  = 1'b1;
        exp_q.delete();
        exp_q.push_back(12'd0);
    endtask

    task automatic wait_trig(input int budget, input string tag, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (dactrig === 1'b1) begin
                at = cyc;
                break;
            end
            tick();
        end
        if (at < 0) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pop_check(input string tag);
        logic [11:0] e;
        if (exp_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, 32'(data), 32'(e));
        end
    endtask

    // Serializer model: called in the dactrig cycle, answers dacdone after dly cycles.
    task automatic transfer(input int dly, input string tag);
        pop_check(tag);
        check_val({tag, "_addr"}, 32'(address), 32'(chan));
        check_val({tag, "_busy_trig"}, 32'(busy), 32'd1);
        repeat (dly) tick();
        check_val({tag, "_trig_pulse"}, 32'(dactrig), 32'd0);
        check_val({tag, "_busy_wait"}, 32'(busy), 32'd1);
        dacdone = 1'b1;
        model_adv();
        tick();
        dacdone = 1'b0;
        check_val({tag, "_adv"}, 32'(data), 32'(m_data));
    endtask

    initial begin
        int t0;
        int t1;
        int tstart;
        int ntrig;

        // ---- reset values and sawtooth with wrap ----
        do_reset();
        check_val("rst_data", 32'(data), 32'd0);
        check_val("rst_addr", 32'(address), 32'd0);
        check_val("rst_cmd", 32'(command), 32'd3);
        check_val("rst_trig", 32'(dactrig), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_ovr", 32'(overrun), 32'd0);

        period = 16'd9; step = 12'd256; chan = 4'd2; mode = 1'b0;
        tstart = cyc;
        en = 1'b1;
        wait_trig(50, "saw_first", t0);
        check_val("saw_first_lat", 32'(t0 - tstart), 32'd11);
        for (int k = 0; k < 17; k++) begin
            transfer(5, "saw");
            if (k < 16) begin
                wait_trig(30, "saw", t1);
                check_val("saw_spacing", 32'(t1 - t0), 32'd10);
                t0 = t1;
            end
        end
        check_val("saw_ovr", 32'(overrun), 32'd0);

        // ---- wrap from 4090 with step 10 ----
        do_reset();
        period = 16'd3; step = 12'd2045; chan = 4'd7;
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_trig(30, "wrap", t0);
            if (k == 2) step = 12'd10;
            transfer(2, "wrap");
        end
        check_val("wrap_val", 32'(data), 32'd14);

        // ---- triangle (sawtooth when the triangle path is not built) ----
        do_reset();
        period = 16'd9; step = 12'd1000; chan = 4'd1; mode = 1'b1;
        en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            wait_trig(30, "tri", t0);
            transfer(3, "tri");
        end

        // ---- overrun, pending transfer, en dropped in WAIT, clr_ovr ----
        do_reset();
        period = 16'd2; step = 12'd1; chan = 4'd3;
        en = 1'b1;
        wait_trig(30, "ovr", t0);
        pop_check("ovr_first");
        repeat (40) tick();
        check_val("ovr_set", 32'(overrun), 32'd1);
        check_val("ovr_busy", 32'(busy), 32'd1);
        dacdone = 1'b1;
        model_adv();
        tick();
        dacdone = 1'b0;
        check_val("pend_trig", 32'(dactrig), 32'd1);
        pop_check("pend_data");
        tick();
        en = 1'b0;
        repeat (2) tick();
        check_val("endrop_busy", 32'(busy), 32'd1);
        dacdone = 1'b1;
        model_adv();
        tick();
        dacdone = 1'b0;
        ntrig = 0;
        for (int i = 0; i < 20; i++) begin
            if (dactrig === 1'b1) ntrig++;
            tick();
        end
        check_val("endrop_no_trig", 32'(ntrig), 32'd0);
        check_val("endrop_idle", 32'(busy), 32'd0);
        pop_check("endrop_hold");
        check_val("ovr_sticky", 32'(overrun), 32'd1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check_val("ovr_clr", 32'(overrun), 32'd0);

        // ---- asynchronous reset during WAIT ----
        do_reset();
        period = 16'd9; step = 12'd100; chan = 4'd5;
        en = 1'b1;
        wait_trig(30, "rstw", t0);
        transfer(3, "rstw");
        wait_trig(30, "rstw2", t0);
        pop_check("rstw_second");
        repeat (3) tick();
        RST = 1'b1;
        #2;
        check_val("rstw_data", 32'(data), 32'd0);
        check_val("rstw_addr", 32'(address), 32'd0);
        check_val("rstw_cmd", 32'(command), 32'd3);
        check_val("rstw_trig", 32'(dactrig), 32'd0);
        check_val("rstw_busy", 32'(busy), 32'd0);
        check_val("rstw_ovr", 32'(overrun), 32'd0);
        do_reset();
        en = 1'b1;
        wait_trig(30, "rstw_after", t0);
        pop_check("rstw_first_after");
        check_val("rstw_addr_after", 32'(address), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
